// File: rtl/universal_shift_register_if.sv
// Command/status bundle for universal_shift_register; the controller drives
// the master side and the register presents the slave side.
interface universal_shift_register_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
);
    logic             cl_i;
    logic             ld_i;
    logic [WIDTH-1:0] in_i;
    logic             inc_i;
    logic             dec_i;
    logic             start_i;
    logic             dir_i;
    logic [1:0]       mode_i;
    logic [SHW-1:0]   amt_i;
    logic             ir_i;
    logic             il_i;
    logic [WIDTH-1:0] out_o;
    logic             carry_o;
    logic             zero_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output cl_i, ld_i, in_i, inc_i, dec_i, start_i, dir_i, mode_i, amt_i, ir_i, il_i,
        input  out_o, carry_o, zero_o, busy_o, done_o
    );

    modport slave (
        input  cl_i, ld_i, in_i, inc_i, dec_i, start_i, dir_i, mode_i, amt_i, ir_i, il_i,
        output out_o, carry_o, zero_o, busy_o, done_o
    );
endinterface

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal register: clear/load/inc/dec plus serial multi-position shift/rotate.
// Define UREG_SATURATE_EN to make inc/dec saturate instead of wrapping.
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input logic                         clk,
    input logic                         rst,
    universal_shift_register_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = (SHW > CW) ? SHW : CW;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;

    logic [AW-1:0]    amtWide;
    logic [CW-1:0]    amtClamped;
    logic             shiftOut;
    logic             fillBit;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        amtWide = AW'(bus.amt_i);
        if (amtWide >= AW'(WIDTH)) begin
            amtClamped = CW'(WIDTH);
        end else begin
            amtClamped = CW'(amtWide);
        end
    end

    // One shift position; rotate-through-carry feeds the old carry back in.
    always_comb begin
        shiftOut = dir_q ? out_q[WIDTH-1] : out_q[0];
        case (mode_q)
            2'b00:   fillBit = dir_q ? bus.il_i : bus.ir_i;
            2'b01:   fillBit = dir_q ? 1'b0 : out_q[WIDTH-1];
            2'b10:   fillBit = shiftOut;
            default: fillBit = carry_q;
        endcase
        shifted = dir_q ? {out_q[WIDTH-2:0], fillBit} : {fillBit, out_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cl_i) begin
                    out_d   = '0;
                    carry_d = 1'b0;
                end else if (bus.ld_i) begin
                    out_d   = bus.in_i;
                    carry_d = 1'b0;
                end else if (bus.inc_i) begin
                    carry_d = &out_q;
`ifdef UREG_SATURATE_EN
                    out_d = (&out_q) ? out_q : out_q + WIDTH'(1);
`else
                    out_d = out_q + WIDTH'(1);
`endif
                end else if (bus.dec_i) begin
                    carry_d = (out_q == '0);
`ifdef UREG_SATURATE_EN
                    out_d = (out_q == '0) ? out_q : out_q - WIDTH'(1);
`else
                    out_d = out_q - WIDTH'(1);
`endif
                end else if (bus.start_i) begin
                    dir_d  = bus.dir_i;
                    mode_d = bus.mode_i;
                    cnt_d  = amtClamped;
                    if (amtClamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // Only clear is honoured mid-shift, and it suppresses done.
                if (bus.cl_i) begin
                    out_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    out_d   = shifted;
                    carry_d = shiftOut;
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign bus.out_o   = out_q;
    assign bus.carry_o = carry_q;
    assign bus.zero_o  = (out_q == '0);
    assign bus.busy_o  = (state_q == SHIFT);
    assign bus.done_o  = done_q;
endmodule

// File: tb/tb_universal_shift_register.sv
// Directed, scoreboard-based bench for universal_shift_register (WIDTH=8, SHW=4).
// Expected inc/dec results follow UREG_SATURATE_EN when it is defined.
module tb_universal_shift_register;
    localparam int WIDTH = 8;
    localparam int SHW   = 4;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] out;
        logic             carry;
        int               busyCycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic [WIDTH:0] model;

    universal_shift_register_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    universal_shift_register #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cl, input logic ld, input logic inc, input logic dec,
                                 input logic [WIDTH-1:0] inVal);
        bus.cl_i  = cl;
        bus.ld_i  = ld;
        bus.inc_i = inc;
        bus.dec_i = dec;
        bus.in_i  = inVal;
        tick();
        bus.cl_i  = 1'b0;
        bus.ld_i  = 1'b0;
        bus.inc_i = 1'b0;
        bus.dec_i = 1'b0;
    endtask

    // Independent reference for n shift positions; irSeq[i] is the fill bit of shift i.
    function automatic logic [WIDTH:0] refShift(input logic [WIDTH-1:0] v, input logic c, input logic d,
                                                input logic [1:0] m, input int n,
                                                input logic [WIDTH-1:0] irSeq, input logic ilBit);
        logic outBit;
        logic fill;
        for (int i = 0; i < n; i++) begin
            outBit = d ? v[WIDTH-1] : v[0];
            case (m)
                2'b00:   fill = d ? ilBit : irSeq[i];
                2'b01:   fill = d ? 1'b0 : v[WIDTH-1];
                2'b10:   fill = outBit;
                default: fill = c;
            endcase
            v = d ? {v[WIDTH-2:0], fill} : {fill, v[WIDTH-1:1]};
            c = outBit;
        end
        return {c, v};
    endfunction

    task automatic runShift(input string tag, input logic d, input logic [1:0] m, input logic [SHW-1:0] a,
                            input logic [WIDTH-1:0] irSeq, input int expBusy,
                            input logic [WIDTH-1:0] expOut, input logic expCarry);
        int   busyCnt = 0;
        int   k = 0;
        bit   finished = 1'b0;
        exp_t e;
        sb.push_back('{tag, expOut, expCarry, expBusy});
        bus.dir_i   = d;
        bus.mode_i  = m;
        bus.amt_i   = a;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int c = 0; c < WIDTH + 4 && !finished; c++) begin
            if (bus.done_o === 1'b1) begin
                finished = 1'b1;
            end else begin
                if (bus.busy_o === 1'b1) begin
                    busyCnt++;
                    if (k < WIDTH) bus.ir_i = irSeq[k];
                    k++;
                end
                tick();
            end
        end
        checkOutput({tag, "_done_seen"}, 32'(finished), 32'd1);
        e = sb.pop_front();
        checkOutput({e.tag, "_busy_cycles"}, 32'(busyCnt), 32'(e.busyCycles));
        checkOutput({e.tag, "_out"}, 32'(bus.out_o), 32'(e.out));
        checkOutput({e.tag, "_carry"}, 32'(bus.carry_o), 32'(e.carry));
        tick();
        checkOutput({e.tag, "_done_single"}, 32'(bus.done_o), 32'd0);
    endtask

    initial begin
        bus.cl_i = 1'b0; bus.ld_i = 1'b0; bus.in_i = '0; bus.inc_i = 1'b0; bus.dec_i = 1'b0;
        bus.start_i = 1'b0; bus.dir_i = 1'b0; bus.mode_i = 2'b00; bus.amt_i = '0;
        bus.ir_i = 1'b0; bus.il_i = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_out", 32'(bus.out_o), 32'h0);
        checkOutput("reset_carry", 32'(bus.carry_o), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("reset_done", 32'(bus.done_o), 32'd0);
        checkOutput("reset_zero", 32'(bus.zero_o), 32'd1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h96);
        checkOutput("ld96_out", 32'(bus.out_o), 32'h96);
        runShift("asr3", 1'b0, 2'b01, 4'd3, 8'h00, 3, 8'hF2, 1'b1);
        checkOutput("asr3_zero", 32'(bus.zero_o), 32'd0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h81);
        runShift("rol1", 1'b1, 2'b10, 4'd1, 8'h00, 1, 8'h03, 1'b1);
        runShift("rcl8", 1'b1, 2'b11, 4'd8, 8'h00, 8, 8'h81, 1'b1);

        model = refShift(8'h81, 1'b0, 1'b1, 2'b10, WIDTH, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h81);
        runShift("rol_clamp15", 1'b1, 2'b10, 4'd15, 8'h00, WIDTH, model[WIDTH-1:0], model[WIDTH]);

        bus.il_i = 1'b1;
        model = refShift(8'h0F, 1'b0, 1'b1, 2'b00, 3, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h0F);
        runShift("lsl3_il", 1'b1, 2'b00, 4'd3, 8'h00, 3, model[WIDTH-1:0], model[WIDTH]);
        bus.il_i = 1'b0;

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
`ifdef UREG_SATURATE_EN
        checkOutput("incFF_out", 32'(bus.out_o), 32'hFF);
        checkOutput("incFF_zero", 32'(bus.zero_o), 32'd0);
`else
        checkOutput("incFF_out", 32'(bus.out_o), 32'h00);
        checkOutput("incFF_zero", 32'(bus.zero_o), 32'd1);
`endif
        checkOutput("incFF_carry", 32'(bus.carry_o), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
`ifdef UREG_SATURATE_EN
        checkOutput("dec00_out", 32'(bus.out_o), 32'h00);
`else
        checkOutput("dec00_out", 32'(bus.out_o), 32'hFF);
`endif
        checkOutput("dec00_carry", 32'(bus.carry_o), 32'd1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h41);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("inc41_out", 32'(bus.out_o), 32'h42);
        checkOutput("inc41_carry", 32'(bus.carry_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("incdec_prio_out", 32'(bus.out_o), 32'h43);

        bus.amt_i = 4'd3;
        bus.start_i = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
        bus.start_i = 1'b0;
        checkOutput("clldstart_out", 32'(bus.out_o), 32'h00);
        checkOutput("clldstart_busy", 32'(bus.busy_o), 32'd0);
        tick();
        checkOutput("clldstart_busy2", 32'(bus.busy_o), 32'd0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
        runShift("amt0", 1'b0, 2'b00, 4'd0, 8'h00, 0, 8'h3C, 1'b0);

        // Abort sequence: ld ignored at busy cycle 1, clear at busy cycle 3.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hAA);
        bus.dir_i = 1'b0; bus.mode_i = 2'b10; bus.amt_i = 4'd5;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        checkOutput("abort_busy1", 32'(bus.busy_o), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
        checkOutput("abort_ld_ignored", 32'(bus.out_o), 32'h55);
        tick();
        checkOutput("abort_shift2", 32'(bus.out_o), 32'hAA);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("abort_out", 32'(bus.out_o), 32'h00);
        checkOutput("abort_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("abort_done", 32'(bus.done_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("abort_no_done", 32'(bus.done_o), 32'd0);
        end

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hAA);
        bus.dir_i = 1'b1; bus.mode_i = 2'b10; bus.amt_i = 4'd5;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        checkOutput("rstmid_pre_out", 32'(bus.out_o), 32'h55);
        checkOutput("rstmid_pre_carry", 32'(bus.carry_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstmid_out", 32'(bus.out_o), 32'h00);
        checkOutput("rstmid_carry", 32'(bus.carry_o), 32'd0);
        checkOutput("rstmid_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("rstmid_zero", 32'(bus.zero_o), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rstmid_after_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("rstmid_after_done", 32'(bus.done_o), 32'd0);

        // Fill bits 1,0,1,1 arrive in that order; the first one ends up at bit 4.
        model = refShift(8'h00, 1'b0, 1'b0, 2'b00, 4, 8'h0D, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        runShift("lsr4_ir", 1'b0, 2'b00, 4'd4, 8'h0D, 4, model[WIDTH-1:0], model[WIDTH]);
        checkOutput("lsr4_ir_value", 32'(model[WIDTH-1:0]), 32'hD0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
